// File: rtl/psg_cmd_pkg.sv
// psg_cmd_pkg: shared types, PSG register codes and byte builders for the
// PSG command writer.
package psg_cmd_pkg;

  typedef enum logic [1:0] {
    KIND_TONE  = 2'd0,
    KIND_ATTN  = 2'd1,
    KIND_NOISE = 2'd2,
    KIND_RSVD  = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_PARK  = 2'd3
  } state_e;

  // How much of a legal write has to reach the PSG.
  typedef enum logic [1:0] {
    PLAN_FULL      = 2'd0,
    PLAN_DATA_ONLY = 2'd1,
    PLAN_SKIP      = 2'd2
  } plan_e;

  localparam logic [2:0] REG_TONE0 = 3'b000;
  localparam logic [2:0] REG_ATTN0 = 3'b001;
  localparam logic [2:0] REG_TONE1 = 3'b010;
  localparam logic [2:0] REG_ATTN1 = 3'b011;
  localparam logic [2:0] REG_TONE2 = 3'b100;
  localparam logic [2:0] REG_ATTN2 = 3'b101;
  localparam logic [2:0] REG_NOISE = 3'b110;
  localparam logic [2:0] REG_ATTN3 = 3'b111;

  // Data byte to the noise register that changes nothing there.
  localparam logic [7:0] PARK_BYTE = 8'h00;

  function automatic logic [2:0] tone_code(input logic [1:0] chan);
    return {chan, 1'b0};
  endfunction

  function automatic logic [2:0] attn_code(input logic [1:0] chan);
    return {chan, 1'b1};
  endfunction

  function automatic logic [7:0] latch_byte(input logic [2:0] code, input logic [3:0] nibble);
    return {1'b1, code, nibble};
  endfunction

  function automatic logic [7:0] tone_data_byte(input logic [9:0] value);
    return {2'b00, value[9:4]};
  endfunction

  // Reserved kind and tone channel 3 have no PSG register behind them.
  function automatic logic request_legal(input kind_e kind, input logic [1:0] chan);
    return (kind != KIND_RSVD) && !((kind == KIND_TONE) && (chan == 2'd3));
  endfunction

endpackage

// File: rtl/psg_cmd_shadow.sv
// psg_cmd_shadow: mirror of the PSG registers and the current PSG latch, used
// to drop redundant writes or shorten a tone write to its data byte.
// Only built when PSG_CMD_WRITER_SHADOW_EN is defined.
module psg_cmd_shadow
  import psg_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       commit,
  input  kind_e      kind,
  input  logic [1:0] chan,
  input  logic [9:0] value,
  output plan_e      plan
);

  logic [3:0] attn_sh [4];
  logic [9:0] tone_sh [3];
  logic [2:0] noise_sh;
  logic [2:0] latch_sh;
  logic [1:0] tone_idx;
  logic       noise_unused;

  // Channel 3 tone requests are dropped upstream; clamp so the lookup stays in range.
  assign tone_idx = (chan == 2'd3) ? 2'd0 : chan;

  // Noise writes are never suppressed (they restart the LFSR on purpose), so
  // the noise mirror is tracked but not consulted.
  assign noise_unused = ^noise_sh;

  // Compare the request against the mirror to decide what must be sent.
  always_comb begin
    plan = PLAN_FULL;
    case (kind)
      KIND_TONE: begin
        if (value == tone_sh[tone_idx]) begin
          plan = PLAN_SKIP;
        end else if ((value[3:0] == tone_sh[tone_idx][3:0]) && (latch_sh == tone_code(chan))) begin
          plan = PLAN_DATA_ONLY;
        end
      end
      KIND_ATTN: begin
        if (value[3:0] == attn_sh[chan]) plan = PLAN_SKIP;
      end
      default: plan = PLAN_FULL;
    endcase
  end

  // Track register contents and which register the PSG latch points at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) attn_sh[i] <= 4'hF;
      for (int i = 0; i < 3; i++) tone_sh[i] <= '0;
      noise_sh <= 3'b100;
      latch_sh <= REG_TONE0;
    end else if (commit) begin
      case (kind)
        KIND_TONE: begin
          tone_sh[tone_idx] <= value;
          if (plan == PLAN_FULL) latch_sh <= tone_code(chan);
        end
        KIND_ATTN: begin
          attn_sh[chan] <= value[3:0];
          if (plan == PLAN_FULL) latch_sh <= attn_code(chan);
        end
        KIND_NOISE: begin
          noise_sh <= value[2:0];
          latch_sh <= REG_NOISE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/psg_cmd_writer.sv
// psg_cmd_writer: serialises tone / attenuation / noise writes into the PSG
// latch/data byte sequence, holding each byte HOLD_CYCLES clocks.
// Optional write suppression via the PSG_CMD_WRITER_SHADOW_EN macro.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request; bus holds the last (idempotent) byte
// ST_LATCH | latch byte on the bus (tone, attenuation, noise)
// ST_DATA  | tone data byte on the bus
// ST_PARK  | 0x00 to the noise register so the LFSR is not reset repeatedly
module psg_cmd_writer
  import psg_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES      = 1,
  parameter int unsigned FREQUENCY_BITS   = 10,
  parameter int unsigned ATTENUATION_BITS = 4,
  parameter int unsigned NOISE_BITS       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_kind,
  input  logic [1:0]                req_chan,
  input  logic [FREQUENCY_BITS-1:0] req_value,
  output logic [7:0]                psg_data,
  output logic                      byte_strobe,
  output logic                      req_error
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_e                      state;
  state_e                      after_latch;
  logic   [7:0]                hold_cnt;
  logic   [7:0]                next_byte;

  kind_e                       kind;
  logic                        accept;
  logic                        legal;
  plan_e                       plan;
  logic   [ATTENUATION_BITS-1:0] attn_value;
  logic   [NOISE_BITS-1:0]     noise_value;
  logic   [7:0]                first_byte;
  logic   [7:0]                second_byte;
  state_e                      after_first;

  assign kind        = kind_e'(req_kind);
  assign accept      = req_valid && req_ready;
  assign legal       = request_legal(kind, req_chan);
  assign attn_value  = req_value[ATTENUATION_BITS-1:0];
  assign noise_value = req_value[NOISE_BITS-1:0];

`ifdef PSG_CMD_WRITER_SHADOW_EN
  psg_cmd_shadow u_shadow (
    .clk    (clk),
    .reset  (reset),
    .commit (accept && legal),
    .kind   (kind),
    .chan   (req_chan),
    .value  (req_value),
    .plan   (plan)
  );
`else
  assign plan = PLAN_FULL;
`endif

  // Build the byte pair for the incoming request and where the latch step leads.
  always_comb begin
    first_byte  = PARK_BYTE;
    second_byte = PARK_BYTE;
    after_first = ST_IDLE;
    case (kind)
      KIND_TONE: begin
        first_byte  = latch_byte(tone_code(req_chan), req_value[3:0]);
        second_byte = tone_data_byte(req_value);
        after_first = ST_DATA;
      end
      KIND_ATTN: begin
        first_byte  = latch_byte(attn_code(req_chan), attn_value);
        after_first = ST_IDLE;
      end
      KIND_NOISE: begin
        first_byte  = latch_byte(REG_NOISE, {1'b0, noise_value});
        second_byte = PARK_BYTE;
        after_first = ST_PARK;
      end
      default: ;
    endcase
  end

  // Sequencer: accept, emit each byte for HOLD_CYCLES, return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      after_latch <= ST_IDLE;
      hold_cnt    <= '0;
      next_byte   <= PARK_BYTE;
      psg_data    <= 8'h00;
      req_ready   <= 1'b1;
      byte_strobe <= 1'b0;
      req_error   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      req_error   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!legal) begin
              req_error <= 1'b1;
            end else begin
              case (plan)
                PLAN_FULL: begin
                  state       <= ST_LATCH;
                  after_latch <= after_first;
                  next_byte   <= second_byte;
                  psg_data    <= first_byte;
                  byte_strobe <= 1'b1;
                  hold_cnt    <= HOLD_LOAD;
                  req_ready   <= 1'b0;
                end
                PLAN_DATA_ONLY: begin
                  state       <= ST_DATA;
                  psg_data    <= second_byte;
                  byte_strobe <= 1'b1;
                  hold_cnt    <= HOLD_LOAD;
                  req_ready   <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_LATCH: begin
          if (hold_cnt == 8'd0) begin
            if (after_latch == ST_IDLE) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
            end else begin
              state       <= after_latch;
              psg_data    <= next_byte;
              byte_strobe <= 1'b1;
              hold_cnt    <= HOLD_LOAD;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        ST_DATA, ST_PARK: begin
          if (hold_cnt == 8'd0) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
